// File: rtl/rng_arb_pkg.sv
// Shared types and sizing for the RNG SOP arbiter.
// Burst length helper maps a zero word count to a full 16-word burst.
package rng_arb_pkg;

    localparam int NUM_REQ = 2;
    localparam int WORD_W  = 128;
    localparam int LEN_W   = 4;
    localparam int TMO_W   = 16;
    localparam int CNT_W   = LEN_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_SEL,
        ST_WAIT,
        ST_XFER
    } arb_state_t;

    function automatic logic [CNT_W-1:0] burst_len(input logic [LEN_W-1:0] words);
        return (words == '0) ? CNT_W'(1 << LEN_W) : {1'b0, words};
    endfunction

endpackage

// File: rtl/rng_timeout_cnt.sv
// Counts consecutive WAIT cycles without data.
// Flags the cycle that reaches a non-zero limit.
module rng_timeout_cnt
    import rng_arb_pkg::*;
(
    input  logic             rng_clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [TMO_W-1:0] limit,
    output logic             terminal
);

    logic [TMO_W-1:0] count;
    logic [TMO_W-1:0] count_inc;

    assign count_inc = count + TMO_W'(1);
    assign terminal  = enable && (limit != '0) && (count_inc == limit);

    always_ff @(posedge rng_clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count_inc;
        end
    end

endmodule

// File: rtl/rng_sop_arbiter.sv
// Round-robin arbiter handing bursts of SOP random words to two requesters.
// Each word is registered and handed over with a valid/ready handshake.
module rng_sop_arbiter
    import rng_arb_pkg::*;
(
    input  logic                     rng_clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_src,
    input  logic [NUM_REQ*LEN_W-1:0] req_words,
    input  logic [WORD_W-1:0]        sop_data,
    input  logic                     sop_valid,
    output logic                     sop_sel,
    output logic                     sop_ack,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [WORD_W-1:0]        rsp_data,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic                     rsp_last,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    input  logic [TMO_W-1:0]         timeout_cfg,
    output logic                     timeout_err,
    output logic                     busy
);

    arb_state_t       state;
    arb_state_t       next_state;
    logic             last_b;
    logic [CNT_W-1:0] word_cnt;
    logic             win_b;
    logic [LEN_W-1:0] win_words;
    logic             handshake;
    logic             tmo_hit;
    logic             do_grant;
    logic             do_capture;
    logic             do_accept;
    logic             do_release;
    logic             do_timeout;

    // B wins when it is alone, or on a tie when A was served last.
    assign win_b     = req_valid[1] && (!req_valid[0] || !last_b);
    assign win_words = win_b ? req_words[2*LEN_W-1:LEN_W] : req_words[LEN_W-1:0];
    assign handshake = |(rsp_valid & rsp_ready & gnt);

    assign sop_ack  = do_accept;
    assign rsp_last = (|rsp_valid) && (word_cnt == CNT_W'(1));
    assign busy     = (state != ST_IDLE);

    rng_timeout_cnt u_timeout (
        .rng_clk  (rng_clk),
        .rst_n    (rst_n),
        .clear    (state != ST_WAIT),
        .enable   ((state == ST_WAIT) && !sop_valid),
        .limit    (timeout_cfg),
        .terminal (tmo_hit)
    );

    always_ff @(posedge rng_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        do_grant   = 1'b0;
        do_capture = 1'b0;
        do_accept  = 1'b0;
        do_release = 1'b0;
        do_timeout = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|req_valid) next_state = ST_ARB;
            end
            ST_ARB: begin
                if (|req_valid) begin
                    do_grant   = 1'b1;
                    next_state = ST_SEL;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            ST_SEL: begin
                next_state = ST_WAIT;
            end
            // Data arriving on the terminal cycle takes priority over the timeout.
            ST_WAIT: begin
                if (sop_valid) begin
                    do_capture = 1'b1;
                    next_state = ST_XFER;
                end else if (tmo_hit) begin
                    do_timeout = 1'b1;
                    do_release = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (handshake) begin
                    do_accept = 1'b1;
                    if (word_cnt == CNT_W'(1)) begin
                        do_release = 1'b1;
                        next_state = ST_IDLE;
                    end else if (|(req_valid & gnt)) begin
                        next_state = ST_WAIT;
                    end else begin
                        do_release = 1'b1;
                        next_state = ST_IDLE;
                    end
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Every burst end, including timeouts and early aborts, advances the pointer.
    always_ff @(posedge rng_clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt         <= '0;
            sop_sel     <= 1'b0;
            word_cnt    <= '0;
            rsp_data    <= '0;
            rsp_valid   <= '0;
            timeout_err <= 1'b0;
            last_b      <= 1'b1;
        end else begin
            timeout_err <= do_timeout;
            if (do_grant) begin
                gnt      <= {win_b, !win_b};
                sop_sel  <= win_b ? req_src[1] : req_src[0];
                word_cnt <= burst_len(win_words);
            end
            if (do_capture) begin
                rsp_data  <= sop_data;
                rsp_valid <= gnt;
            end
            if (do_accept) begin
                rsp_valid <= '0;
                word_cnt  <= word_cnt - CNT_W'(1);
            end
            if (do_release) begin
                gnt    <= '0;
                last_b <= gnt[1];
            end
        end
    end

endmodule

// File: tb/tb_rng_sop_arbiter.sv
// Directed self-checking bench for rng_sop_arbiter.
// Expected values are hand-computed from the intended burst behaviour.
module tb_rng_sop_arbiter;

    logic         rng_clk;
    logic         rst_n;
    logic [1:0]   req_valid;
    logic [1:0]   req_src;
    logic [7:0]   req_words;
    logic [127:0] sop_data;
    logic         sop_valid;
    logic         sop_sel;
    logic         sop_ack;
    logic [1:0]   gnt;
    logic [127:0] rsp_data;
    logic [1:0]   rsp_valid;
    logic         rsp_last;
    logic [1:0]   rsp_ready;
    logic [15:0]  timeout_cfg;
    logic         timeout_err;
    logic         busy;

    int errors = 0;
    int checks = 0;

    int           acks;
    int           last_idx;
    logic [1:0]   granted;
    logic         sel_seen;
    logic [127:0] first_data;
    logic         flag;
    int           cyc;

    rng_sop_arbiter dut (
        .rng_clk     (rng_clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_src     (req_src),
        .req_words   (req_words),
        .sop_data    (sop_data),
        .sop_valid   (sop_valid),
        .sop_sel     (sop_sel),
        .sop_ack     (sop_ack),
        .gnt         (gnt),
        .rsp_data    (rsp_data),
        .rsp_valid   (rsp_valid),
        .rsp_last    (rsp_last),
        .rsp_ready   (rsp_ready),
        .timeout_cfg (timeout_cfg),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    initial rng_clk = 1'b0;
    always #5 rng_clk = ~rng_clk;

    task automatic tick();
        @(posedge rng_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] src, input logic [7:0] words,
                                 input logic sv, input logic [1:0] ready);
        req_valid = valid;
        req_src   = src;
        req_words = words;
        sop_valid = sv;
        rsp_ready = ready;
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic waitGrant(input int budget);
        int n = 0;
        while (gnt == 2'b00 && n < budget) begin
            tick();
            n++;
        end
        if (gnt == 2'b00) checkOutput("grant_wait", 1'b0, 1'b1);
    endtask

    // Follows one granted burst to its end, counting acks and noting the last-word index.
    task automatic serviceBurst(input logic [1:0] set_mask, input logic [1:0] clr_mask,
                                output int n_ack, output int n_last, output logic [1:0] who,
                                output logic sel, output logic [127:0] data0);
        int n = 0;
        n_ack = 0; n_last = 0; who = 2'b00; sel = 1'b0; data0 = '0;
        waitGrant(100);
        who = gnt;
        sel = sop_sel;
        while (gnt != 2'b00 && n < 200) begin
            if (sop_ack) begin
                n_ack++;
                if (n_ack == 1) begin
                    data0     = rsp_data;
                    req_valid = (req_valid | set_mask) & ~clr_mask;
                end
                if (rsp_last) n_last = n_ack;
            end
            tick();
            n++;
        end
        if (gnt != 2'b00) checkOutput("burst_end_wait", 1'b0, 1'b1);
        req_valid = req_valid & ~who;
    endtask

    initial begin
        rst_n       = 1'b0;
        timeout_cfg = 16'd0;
        sop_data    = '0;
        applyStimulus(2'b00, 2'b00, 8'h00, 1'b0, 2'b00);
        tick();
        tick();
        checkOutput("rst_gnt", gnt, 2'b00);
        checkOutput("rst_rsp_valid", rsp_valid, 2'b00);
        checkOutput("rst_rsp_data", rsp_data, 128'h0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_sop_sel", sop_sel, 1'b0);
        checkOutput("rst_misc", {sop_ack, rsp_last, timeout_err}, 3'b000);
        rst_n = 1'b1;
        tick();

        $display("[TB] A alone, 3 words from TRNG");
        sop_data = {4{32'h1111_2222}};
        applyStimulus(2'b01, 2'b01, 8'h03, 1'b1, 2'b11);
        serviceBurst(2'b00, 2'b00, acks, last_idx, granted, sel_seen, first_data);
        checkOutput("a3_gnt", granted, 2'b01);
        checkOutput("a3_sel", sel_seen, 1'b1);
        checkOutput("a3_acks", acks, 3);
        checkOutput("a3_last_idx", last_idx, 3);
        checkOutput("a3_data", first_data, {4{32'h1111_2222}});
        checkOutput("a3_idle", busy, 1'b0);

        $display("[TB] Tie after reset, then A re-requests during B");
        applyReset();
        applyStimulus(2'b11, 2'b10, 8'h11, 1'b1, 2'b11);
        serviceBurst(2'b00, 2'b00, acks, last_idx, granted, sel_seen, first_data);
        checkOutput("tie_first_gnt", granted, 2'b01);
        checkOutput("tie_first_sel", sel_seen, 1'b0);
        checkOutput("tie_first_last", last_idx, 1);
        serviceBurst(2'b01, 2'b00, acks, last_idx, granted, sel_seen, first_data);
        checkOutput("tie_second_gnt", granted, 2'b10);
        checkOutput("tie_second_sel", sel_seen, 1'b1);
        serviceBurst(2'b00, 2'b00, acks, last_idx, granted, sel_seen, first_data);
        checkOutput("rereq_gnt", granted, 2'b01);

        $display("[TB] B times out with limit 5");
        timeout_cfg = 16'd5;
        applyStimulus(2'b10, 2'b00, 8'h11, 1'b0, 2'b11);
        waitGrant(20);
        flag = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (timeout_err !== 1'b0 || sop_ack !== 1'b0 || gnt !== 2'b10) flag = 1'b0;
        end
        checkOutput("tmo_not_early", flag, 1'b1);
        tick();
        checkOutput("tmo_err_pulse", timeout_err, 1'b1);
        checkOutput("tmo_gnt_clear", gnt, 2'b00);
        checkOutput("tmo_idle", busy, 1'b0);
        req_valid = 2'b00;
        tick();
        checkOutput("tmo_err_one_cycle", timeout_err, 1'b0);

        $display("[TB] Tie after B timeout goes to A");
        applyStimulus(2'b11, 2'b00, 8'h11, 1'b1, 2'b11);
        serviceBurst(2'b00, 2'b00, acks, last_idx, granted, sel_seen, first_data);
        checkOutput("tmo_rr_gnt", granted, 2'b01);
        serviceBurst(2'b00, 2'b00, acks, last_idx, granted, sel_seen, first_data);
        checkOutput("tmo_rr_next", granted, 2'b10);

        $display("[TB] Data on the terminal WAIT cycle");
        applyStimulus(2'b01, 2'b00, 8'h01, 1'b0, 2'b11);
        waitGrant(20);
        flag = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (timeout_err !== 1'b0) flag = 1'b0;
        end
        checkOutput("race_no_early_err", flag, 1'b1);
        sop_valid = 1'b1;
        sop_data  = {4{32'hCAFE_F00D}};
        tick();
        checkOutput("race_rsp_valid", rsp_valid, 2'b01);
        checkOutput("race_rsp_data", rsp_data, {4{32'hCAFE_F00D}});
        checkOutput("race_ack_last", {sop_ack, rsp_last}, 2'b11);
        checkOutput("race_no_err", timeout_err, 1'b0);
        req_valid = 2'b00;
        tick();
        checkOutput("race_done", {gnt, timeout_err}, 3'b000);

        $display("[TB] Zero word count gives 16 words");
        timeout_cfg = 16'd0;
        applyStimulus(2'b01, 2'b01, 8'h00, 1'b1, 2'b11);
        serviceBurst(2'b00, 2'b00, acks, last_idx, granted, sel_seen, first_data);
        checkOutput("w16_acks", acks, 16);
        checkOutput("w16_last_idx", last_idx, 16);

        $display("[TB] Stall with rsp_ready low");
        sop_data = {4{32'hD00D_0001}};
        applyStimulus(2'b01, 2'b00, 8'h02, 1'b1, 2'b00);
        cyc = 0;
        while (rsp_valid == 2'b00 && cyc < 50) begin
            tick();
            cyc++;
        end
        checkOutput("stall_rsp_valid", rsp_valid, 2'b01);
        flag = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sop_data = {4{32'hC0DE_0000 + i}};
            tick();
            if (rsp_data !== {4{32'hD00D_0001}} || sop_ack !== 1'b0 || rsp_valid !== 2'b01) flag = 1'b0;
        end
        checkOutput("stall_stable", flag, 1'b1);
        rsp_ready = 2'b11;
        #1;
        checkOutput("stall_ack", sop_ack, 1'b1);
        serviceBurst(2'b00, 2'b00, acks, last_idx, granted, sel_seen, first_data);
        checkOutput("stall_acks", acks, 2);
        checkOutput("stall_last_idx", last_idx, 2);

        $display("[TB] B drops request after word 1 of 4");
        applyStimulus(2'b10, 2'b00, 8'h40, 1'b1, 2'b11);
        serviceBurst(2'b00, 2'b10, acks, last_idx, granted, sel_seen, first_data);
        checkOutput("abort_gnt", granted, 2'b10);
        checkOutput("abort_acks", acks, 1);
        checkOutput("abort_no_last", last_idx, 0);

        $display("[TB] Reset asserted in WAIT");
        applyStimulus(2'b01, 2'b01, 8'h02, 1'b0, 2'b11);
        waitGrant(20);
        tick();
        checkOutput("rstw_pre", {busy, sop_sel}, 2'b11);
        rst_n = 1'b0;
        #1;
        checkOutput("rstw_gnt", gnt, 2'b00);
        checkOutput("rstw_sel_busy", {sop_sel, busy}, 2'b00);
        tick();
        checkOutput("rstw_data", rsp_data, 128'h0);
        checkOutput("rstw_pulses", {sop_ack, timeout_err, rsp_last, rsp_valid}, 5'b00000);
        req_valid = 2'b00;
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
